branch_predictor: RTL



---
 rtl/branch_predictor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor: 2-bit counter PHT, direct-mapped BTB, mispredict counter.
// Define BP_GSHARE_EN to XOR a live global history register into the PHT index (gshare).
module branch_predictor #(
  parameter int         PHT_IDX_W = 5,
  parameter int         BTB_IDX_W = 4,
  parameter logic [1:0] PHT_INIT  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 F_valid,
  input  logic [31:0]          F_PC,
  output logic                 F_pred_taken,
  output logic [PHT_IDX_W-1:0] F_pht_idx,
  output logic                 F_btb_hit,
  output logic [31:0]          F_btb_target,
  output logic [31:0]          F_pred_next_pc,
  input  logic                 E_update_en,
  input  logic [31:0]          E_PC,
  input  logic [PHT_IDX_W-1:0] E_pht_idx,
  input  logic                 E_actual_taken,
  input  logic [31:0]          E_actual_target,
  input  logic                 E_redirect_valid,
  output logic [31:0]          mispred_cnt
);

  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 32 - BTB_IDX_W - 2;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'b01;
      else              res = ctr;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'b01;
      else              res = ctr;
    end
    return res;
  endfunction

  logic [PHT_N-1:0][1:0]       pht_q, pht_d;
  logic [BTB_N-1:0]            btb_valid_q, btb_valid_d;
  logic [BTB_N-1:0][TAG_W-1:0] btb_tag_q, btb_tag_d;
  logic [BTB_N-1:0][31:0]      btb_target_q, btb_target_d;
  logic [31:0]                 cnt_q, cnt_d;
  logic [PHT_IDX_W-1:0]        ghr_s;

  logic [PHT_IDX_W-1:0]        look_idx_s;
  logic [BTB_IDX_W-1:0]        look_btb_idx_s;
  logic                        look_match_s;
  logic [31:0]                 pc_plus4_s;
  logic [BTB_IDX_W-1:0]        upd_btb_idx_s;
  logic                        unused_s;

  assign unused_s      = ^{F_PC[1:0], E_PC[1:0]};
  assign upd_btb_idx_s = E_PC[BTB_IDX_W+1:2];
  assign mispred_cnt   = cnt_q;

`ifdef BP_GSHARE_EN
  logic [PHT_IDX_W-1:0] ghr_q, ghr_d;

  // History shifts in every resolved direction, oldest bit falls off the top.
  always_comb begin
    ghr_d = ghr_q;
    if (E_update_en) ghr_d = {ghr_q[PHT_IDX_W-2:0], E_actual_taken};
    else             ghr_d = ghr_q;
  end

  // Global history register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ghr_q <= {PHT_IDX_W{1'b0}};
    else      ghr_q <= ghr_d;
  end

  assign ghr_s = ghr_q;
`else
  assign ghr_s = {PHT_IDX_W{1'b0}};
`endif

  // Lookup reads only registered state, so a same-cycle update is seen one cycle later.
  always_comb begin
    look_idx_s     = F_PC[PHT_IDX_W+1:2] ^ ghr_s;
    look_btb_idx_s = F_PC[BTB_IDX_W+1:2];
    look_match_s   = btb_valid_q[look_btb_idx_s] &&
                     (btb_tag_q[look_btb_idx_s] == F_PC[31:BTB_IDX_W+2]);
    pc_plus4_s     = F_PC + 32'd4;
    F_pred_taken   = 1'b0;
    F_pht_idx      = {PHT_IDX_W{1'b0}};
    F_btb_hit      = 1'b0;
    F_btb_target   = 32'd0;
    if (F_valid) begin
      F_pred_taken = pht_q[look_idx_s][1];
      F_pht_idx    = look_idx_s;
      F_btb_hit    = look_match_s;
      F_btb_target = look_match_s ? btb_target_q[look_btb_idx_s] : 32'd0;
    end else begin
      F_pred_taken = 1'b0;
      F_pht_idx    = {PHT_IDX_W{1'b0}};
      F_btb_hit    = 1'b0;
      F_btb_target = 32'd0;
    end
    F_pred_next_pc = (F_pred_taken && F_btb_hit) ? F_btb_target : pc_plus4_s;
  end

  // Training: counter moves toward the outcome; taken branches (re)allocate their BTB slot.
  always_comb begin
    pht_d        = pht_q;
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (E_update_en) begin
      pht_d[E_pht_idx] = sat_update(pht_q[E_pht_idx], E_actual_taken);
      if (E_actual_taken) begin
        btb_valid_d[upd_btb_idx_s]  = 1'b1;
        btb_tag_d[upd_btb_idx_s]    = E_PC[31:BTB_IDX_W+2];
        btb_target_d[upd_btb_idx_s] = E_actual_target;
      end else begin
        btb_valid_d = btb_valid_q;
      end
    end else begin
      pht_d = pht_q;
    end
  end

  // Mispredict counter, free-running and wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (E_redirect_valid) cnt_d = cnt_q + 32'd1;
    else                  cnt_d = cnt_q;
  end

  // Predictor tables and counter; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pht_q        <= {PHT_N{PHT_INIT}};
      btb_valid_q  <= {BTB_N{1'b0}};
      btb_tag_q    <= {BTB_N{{TAG_W{1'b0}}}};
      btb_target_q <= {BTB_N{32'd0}};
      cnt_q        <= 32'd0;
    end else begin
      pht_q        <= pht_d;
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule
